ahb_slave_decode_mux: RTL and testbench



---
 rtl/ahb_slave_decode_mux.sv | 113 +++++++++++
 tb/tb_ahb_slave_decode_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_decode_mux.sv
// AHB address decoder, data-phase response mux and default ERROR slave.
// Optional feature macro AHB_DECODE_ERRCNT_EN adds a saturating error counter (err_count/err_clr).
module ahb_slave_decode_mux #(
   parameter int unsigned NSLV   = 3,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned DATA_W = 8
) (
   input  logic                   hclk,
   input  logic                   hreset,
   input  logic [ADDR_W-1:0]      haddr,
   input  logic [1:0]             htrans,
   output logic [NSLV-1:0]        hsel,
   input  logic [NSLV-1:0]        hreadyout_s,
   input  logic [2*NSLV-1:0]      hresp_s,
   input  logic [DATA_W*NSLV-1:0] hrdata_s,
`ifdef AHB_DECODE_ERRCNT_EN
   input  logic                   err_clr,
   output logic [7:0]             err_count,
`endif
   output logic                   hready,
   output logic [1:0]             hresp,
   output logic [DATA_W-1:0]      hrdata
);

   localparam logic [1:0] DS_OK   = 2'd0;
   localparam logic [1:0] DS_ERR1 = 2'd1;
   localparam logic [1:0] DS_ERR2 = 2'd2;

   logic [SEL_W-1:0] idx;
   logic             unmapped;
   logic             err_start;
   logic [SEL_W-1:0] dsel_q;
   logic             dact_q;
   logic [1:0]       ds_q, ds_d;
   logic             ds_hready;
   logic [1:0]       ds_hresp;
   logic             unused_in;

   assign idx       = haddr[ADDR_W-1 -: SEL_W];
   assign unmapped  = int'(idx) >= NSLV;
   assign unused_in = ^{haddr[ADDR_W-SEL_W-1:0], htrans[0]};

   // Address-phase decode; htrans qualification is left to the slaves.
   always_comb begin
      hsel = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (idx == SEL_W'(k)) hsel[k] = 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         dsel_q <= '1;
         dact_q <= 1'b0;
      end else if (hready) begin
         dsel_q <= idx;
         dact_q <= htrans[1];
      end
   end

   // Only an active transfer to an unmapped address starts the ERROR response.
   assign err_start = hready && unmapped && htrans[1];

   always_comb begin
      ds_d = ds_q;
      case (ds_q)
         DS_OK:   if (err_start) ds_d = DS_ERR1;
         DS_ERR1: ds_d = DS_ERR2;
         DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_OK;
         default: ds_d = DS_OK;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) ds_q <= DS_OK;
      else         ds_q <= ds_d;
   end

   // dact is always set while the FSM is in an error state; gating keeps IDLE/BUSY at OKAY.
   assign ds_hready = !((ds_q == DS_ERR1) && dact_q);
   assign ds_hresp  = {1'b0, (ds_q != DS_OK) && dact_q};

   always_comb begin
      hready = ds_hready;
      hresp  = ds_hresp;
      hrdata = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (dsel_q == SEL_W'(k)) begin
            hready = hreadyout_s[k];
            hresp  = hresp_s[2*k +: 2];
            hrdata = hrdata_s[DATA_W*k +: DATA_W];
         end
      end
   end

`ifdef AHB_DECODE_ERRCNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         err_count_q <= 8'd0;
      end else if (err_clr) begin
         err_count_q <= 8'd0;
      end else if (err_start && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ahb_slave_decode_mux.sv
// Bench for ahb_slave_decode_mux: directed scenarios plus random traffic against a transaction-level model.
module tb_ahb_slave_decode_mux;

   localparam int NSLV   = 3;
   localparam int ADDR_W = 8;
   localparam int SEL_W  = 2;
   localparam int DATA_W = 8;

   logic                   hclk = 1'b0;
   logic                   hreset;
   logic [ADDR_W-1:0]      haddr;
   logic [1:0]             htrans;
   logic [NSLV-1:0]        hsel;
   logic [NSLV-1:0]        hreadyout_s;
   logic [2*NSLV-1:0]      hresp_s;
   logic [DATA_W*NSLV-1:0] hrdata_s;
   logic                   hready;
   logic [1:0]             hresp;
   logic [DATA_W-1:0]      hrdata;
`ifdef AHB_DECODE_ERRCNT_EN
   logic                   err_clr;
   logic [7:0]             err_count;
`endif

   int checks = 0;
   int errors = 0;

   // Model: data-phase target (-1 = default slave), position in ERROR response, error count.
   int m_tgt;
   int m_err;
   int m_cnt;
   logic [NSLV-1:0]   exp_hsel;
   logic              exp_hready;
   logic [1:0]        exp_hresp;
   logic [DATA_W-1:0] exp_hrdata;

   always #5 hclk = ~hclk;

   ahb_slave_decode_mux #(
      .NSLV   (NSLV),
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W)
   ) dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .haddr       (haddr),
      .htrans      (htrans),
      .hsel        (hsel),
      .hreadyout_s (hreadyout_s),
      .hresp_s     (hresp_s),
      .hrdata_s    (hrdata_s),
`ifdef AHB_DECODE_ERRCNT_EN
      .err_clr     (err_clr),
      .err_count   (err_count),
`endif
      .hready      (hready),
      .hresp       (hresp),
      .hrdata      (hrdata)
   );

   function automatic void model_reset();
      m_tgt = -1;
      m_err = 0;
      m_cnt = 0;
   endfunction

   function automatic void model_outputs();
      int a;
      a = int'(haddr) / 64;
      exp_hsel = '0;
      if (a < NSLV) exp_hsel[a] = 1'b1;
      if (m_tgt >= 0) begin
         exp_hready = hreadyout_s[m_tgt];
         exp_hresp  = hresp_s[2*m_tgt +: 2];
         exp_hrdata = hrdata_s[8*m_tgt +: 8];
      end else begin
         exp_hready = (m_err != 1);
         exp_hresp  = (m_err != 0) ? 2'b01 : 2'b00;
         exp_hrdata = '0;
      end
   endfunction

   function automatic void model_update();
      int a;
      bit new_err;
      model_outputs();
      a = int'(haddr) / 64;
      new_err = 1'b0;
      if (m_err == 1) begin
         m_err = 2;
      end else if (exp_hready) begin
         m_tgt   = (a < NSLV) ? a : -1;
         new_err = (m_tgt < 0) && (htrans >= 2'b10);
         m_err   = new_err ? 1 : 0;
      end
`ifdef AHB_DECODE_ERRCNT_EN
      if (err_clr) m_cnt = 0;
      else if (new_err && m_cnt < 255) m_cnt++;
`else
      if (new_err && m_cnt < 255) m_cnt++;
`endif
   endfunction

   task automatic tick();
      @(posedge hclk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      hreset = 1'b0;
      haddr = 8'h40; htrans = 2'b00;
      hreadyout_s = '1; hresp_s = '0; hrdata_s = '0;
`ifdef AHB_DECODE_ERRCNT_EN
      err_clr = 1'b0;
`endif
      #2;
      checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready got %b want 1", hready); end
      checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp got %b want 00", hresp); end
      checks++; if (hrdata !== 8'h00) begin errors++; $display("FAIL reset_hrdata got %h want 00", hrdata); end
      checks++; if (hsel !== 3'b010) begin errors++; $display("FAIL reset_hsel got %b want 010", hsel); end
`ifdef AHB_DECODE_ERRCNT_EN
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", err_count); end
`endif
      #1 hreset = 1'b1;
      haddr = 8'h00;
      tick();
   endtask

   task automatic test_mapped_read();
      haddr = 8'h85; htrans = 2'b10; hreadyout_s = '1;
      @(negedge hclk);
      checks++; if (hsel !== 3'b100) begin errors++; $display("FAIL read_hsel got %b want 100", hsel); end
      tick();
      haddr = 8'h00; htrans = 2'b00; hreadyout_s[2] = 1'b0;
      repeat (2) begin
         @(negedge hclk);
         checks++; if (hready !== 1'b0) begin errors++; $display("FAIL read_wait got %b want 0", hready); end
         tick();
      end
      hreadyout_s[2] = 1'b1; hrdata_s[23:16] = 8'hA5;
      @(negedge hclk);
      checks++; if (hready !== 1'b1) begin errors++; $display("FAIL read_ready got %b want 1", hready); end
      checks++; if (hrdata !== 8'hA5) begin errors++; $display("FAIL read_data got %h want a5", hrdata); end
      tick();
   endtask

   task automatic test_unmapped();
      haddr = 8'hC0; htrans = 2'b10;
      @(negedge hclk);
      checks++; if (hsel !== 3'b000) begin errors++; $display("FAIL unm_hsel got %b want 000", hsel); end
      tick();
      haddr = 8'h00; htrans = 2'b00;
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 3'b001) begin errors++; $display("FAIL unm_err1 got %b want 001", {hready, hresp}); end
      checks++; if (hrdata !== 8'h00) begin errors++; $display("FAIL unm_data got %h want 00", hrdata); end
      tick();
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 3'b101) begin errors++; $display("FAIL unm_err2 got %b want 101", {hready, hresp}); end
      tick();
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 3'b100) begin errors++; $display("FAIL unm_ok got %b want 100", {hready, hresp}); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [2:0] want [4];
      int c0;
      want[0] = 3'b001; want[1] = 3'b101; want[2] = 3'b001; want[3] = 3'b101;
      c0 = m_cnt;
      haddr = 8'hC0; htrans = 2'b10;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin haddr = 8'hC4; htrans = 2'b11; end
         if (i == 2) begin haddr = 8'h00; htrans = 2'b00; end
         @(negedge hclk);
         checks++; if ({hready, hresp} !== want[i]) begin errors++; $display("FAIL b2b_%0d got %b want %b", i, {hready, hresp}, want[i]); end
         tick();
      end
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 3'b100) begin errors++; $display("FAIL b2b_ok got %b want 100", {hready, hresp}); end
`ifdef AHB_DECODE_ERRCNT_EN
      checks++; if (int'(err_count) != ((c0 + 2 > 255) ? 255 : c0 + 2)) begin errors++; $display("FAIL b2b_count got %0d want %0d", err_count, c0 + 2); end
`else
      c0 = c0 + 0;
`endif
      tick();
   endtask

   task automatic test_unmapped_idle();
      int c0;
      c0 = m_cnt;
      haddr = 8'hFF; htrans = 2'b00;
      repeat (2) begin
         tick();
         @(negedge hclk);
         checks++; if ({hready, hresp} !== 3'b100) begin errors++; $display("FAIL idle_resp got %b want 100", {hready, hresp}); end
      end
`ifdef AHB_DECODE_ERRCNT_EN
      checks++; if (int'(err_count) != c0) begin errors++; $display("FAIL idle_count got %0d want %0d", err_count, c0); end
`else
      c0 = c0 + 0;
`endif
      tick();
   endtask

   task automatic test_reset_mid_error();
      haddr = 8'hC0; htrans = 2'b10;
      tick();
      haddr = 8'h40; htrans = 2'b00;
      #2;
      checks++; if (hready !== 1'b0) begin errors++; $display("FAIL rst_pre got %b want 0", hready); end
      hreset = 1'b0;
      #1;
      model_reset();
      checks++; if ({hready, hresp} !== 3'b100) begin errors++; $display("FAIL rst_mid got %b want 100", {hready, hresp}); end
      checks++; if (hrdata !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", hrdata); end
      checks++; if (hsel !== 3'b010) begin errors++; $display("FAIL rst_mid_hsel got %b want 010", hsel); end
      #1 hreset = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         haddr  = ADDR_W'($urandom);
         htrans = 2'($urandom);
         for (int k = 0; k < NSLV; k++) begin
            hreadyout_s[k]  = ($urandom_range(0, 3) != 0);
            hresp_s[2*k +: 2] = {1'b0, 1'($urandom_range(0, 5) == 0)};
            hrdata_s[8*k +: 8] = 8'($urandom);
         end
`ifdef AHB_DECODE_ERRCNT_EN
         err_clr = ($urandom_range(0, 15) == 0);
`endif
         @(negedge hclk);
         model_outputs();
         checks++; if (hsel !== exp_hsel) begin errors++; $display("FAIL rnd_hsel n=%0d got %b want %b", n, hsel, exp_hsel); end
         checks++; if (hready !== exp_hready) begin errors++; $display("FAIL rnd_hready n=%0d got %b want %b", n, hready, exp_hready); end
         checks++; if (hresp !== exp_hresp) begin errors++; $display("FAIL rnd_hresp n=%0d got %b want %b", n, hresp, exp_hresp); end
         checks++; if (hrdata !== exp_hrdata) begin errors++; $display("FAIL rnd_hrdata n=%0d got %h want %h", n, hrdata, exp_hrdata); end
`ifdef AHB_DECODE_ERRCNT_EN
         checks++; if (int'(err_count) != m_cnt) begin errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, err_count, m_cnt); end
`endif
         tick();
      end
`ifdef AHB_DECODE_ERRCNT_EN
      err_clr = 1'b0;
`endif
      hreadyout_s = '1; hresp_s = '0;
   endtask

`ifdef AHB_DECODE_ERRCNT_EN
   task automatic test_counter();
      haddr = 8'hC0; htrans = 2'b10; err_clr = 1'b0;
      repeat (600) tick();
      @(negedge hclk);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d want 255", err_count); end
      err_clr = 1'b1;
      repeat (2) tick();
      err_clr = 1'b0; htrans = 2'b00;
      @(negedge hclk);
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", err_count); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_mapped_read();
      test_unmapped();
      test_back_to_back();
      test_unmapped_idle();
      test_reset_mid_error();
      test_random();
`ifdef AHB_DECODE_ERRCNT_EN
      test_counter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
